// File: rtl/sap_cpu_pkg.sv
// Shared definitions for the single-accumulator CPU: opcodes, FSM states, default widths.
package sap_cpu_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_OPC_W  = 4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_F1,
    ST_F2,
    ST_E1,
    ST_E2,
    ST_E3,
    ST_HALT
  } state_e;

endpackage

// File: rtl/sap_cpu_if.sv
// Host-facing bundle: program-load/run inputs plus output and status signals.
interface sap_cpu_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              run;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              halted;
  logic              busy;
  logic              cf;
  logic              zf;

  modport master (
    output prog_we, prog_addr, prog_data, run,
    input  out_data, out_valid, halted, busy, cf, zf
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, run,
    output out_data, out_valid, halted, busy, cf, zf
  );
endinterface

// File: rtl/sap_cpu_ram.sv
// Program/data RAM: async read, sync write muxed between host and core, sync clear on reset.
module sap_cpu_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_data_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_data_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  // Host and core writes are never active together; core wins if they were.
  assign we    = host_we_i | core_we_i;
  assign waddr = core_we_i ? core_addr_i : host_addr_i;
  assign wdata = core_we_i ? core_data_i : host_data_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sap_cpu_core.sv
// Single-accumulator CPU: fetch/execute FSM, PC/MAR/IR/A/B/OUT registers, add/sub ALU, flags.
module sap_cpu_core
  import sap_cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int OPC_W  = DEF_OPC_W
) (
  input  logic     clk,
  input  logic     rst,
  sap_cpu_if.slave bus
);
  localparam int IMM_W = DATA_W - OPC_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
  logic              cf_q, cf_d, zf_q, zf_d, out_valid_q, out_valid_d;
  logic [DATA_W-1:0] ram_rdata;
  logic              host_we, core_we, busy;
  logic [OPC_W-1:0]  opc_ir, opc_f;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] imm;
  logic [DATA_W:0]   alu_sum;

  function automatic logic [DATA_W:0] alu_add(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic sub);
    logic [DATA_W-1:0] b_eff;
    b_eff = sub ? ~b : b;
    return {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub};
  endfunction

  // Opcodes with no execute step, including the unused 0x9-0xD range.
  function automatic logic is_nop(input logic [OPC_W-1:0] opc);
    return (opc == OPC_W'(OP_NOP)) || ((opc >= OPC_W'(4'h9)) && (opc <= OPC_W'(4'hD)));
  endfunction

  assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign host_we = bus.prog_we && !busy;
  assign opc_ir  = ir_q[DATA_W-1 -: OPC_W];
  assign opc_f   = ram_rdata[DATA_W-1 -: OPC_W];
  assign operand = ir_q[ADDR_W-1:0];
  assign imm     = {{OPC_W{1'b0}}, ir_q[IMM_W-1:0]};
  assign alu_sum = alu_add(a_q, b_q, opc_ir == OPC_W'(OP_SUB));

  sap_cpu_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk        (clk),
    .rst        (rst),
    .host_we_i  (host_we),
    .host_addr_i(bus.prog_addr),
    .host_data_i(bus.prog_data),
    .core_we_i  (core_we),
    .core_addr_i(mar_q),
    .core_data_i(a_q),
    .raddr_i    (mar_q),
    .rdata_o    (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mar_d       = mar_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    out_d       = out_q;
    cf_d        = cf_q;
    zf_d        = zf_q;
    out_valid_d = 1'b0;
    core_we     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (bus.run) begin
          pc_d    = '0;
          cf_d    = 1'b0;
          zf_d    = 1'b0;
          state_d = ST_F1;
        end
      end
      ST_F1: begin
        mar_d   = pc_q;
        state_d = ST_F2;
      end
      ST_F2: begin
        ir_d    = ram_rdata;
        pc_d    = pc_q + 1'b1;
        state_d = is_nop(opc_f) ? ST_F1 : ST_E1;
      end
      ST_E1: begin
        state_d = ST_F1;
        case (opc_ir)
          OPC_W'(OP_LDA), OPC_W'(OP_ADD), OPC_W'(OP_SUB), OPC_W'(OP_STA): begin
            mar_d   = operand;
            state_d = ST_E2;
          end
          OPC_W'(OP_LDI): a_d = imm;
          OPC_W'(OP_JMP): pc_d = operand;
          OPC_W'(OP_JC):  if (cf_q) pc_d = operand;
          OPC_W'(OP_JZ):  if (zf_q) pc_d = operand;
          OPC_W'(OP_OUT): begin
            out_d       = a_q;
            out_valid_d = 1'b1;
          end
          OPC_W'(OP_HLT): state_d = ST_HALT;
          default: ;
        endcase
      end
      ST_E2: begin
        state_d = ST_F1;
        case (opc_ir)
          OPC_W'(OP_LDA): a_d = ram_rdata;
          OPC_W'(OP_STA): core_we = 1'b1;
          default: begin
            b_d     = ram_rdata;
            state_d = ST_E3;
          end
        endcase
      end
      ST_E3: begin
        a_d     = alu_sum[DATA_W-1:0];
        cf_d    = alu_sum[DATA_W];
        zf_d    = (alu_sum[DATA_W-1:0] == '0);
        state_d = ST_F1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      mar_q       <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_q       <= '0;
      cf_q        <= 1'b0;
      zf_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_q       <= out_d;
      cf_q        <= cf_d;
      zf_q        <= zf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_data  = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.halted    = (state_q == ST_HALT);
  assign bus.busy      = busy;
  assign bus.cf        = cf_q;
  assign bus.zf        = zf_q;

endmodule

// File: tb/tb_sap_cpu_core.sv
// Bench for sap_cpu_core: directed and random programs checked against an instruction-level model.
module tb_sap_cpu_core;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sap_cpu_if #(.DATA_W(8),  .ADDR_W(4)) b8();
  sap_cpu_if #(.DATA_W(12), .ADDR_W(6)) b12();

  sap_cpu_core #(.DATA_W(8),  .ADDR_W(4), .OPC_W(4)) dut   (.clk(clk), .rst(rst), .bus(b8.slave));
  sap_cpu_core #(.DATA_W(12), .ADDR_W(6), .OPC_W(4)) dut12 (.clk(clk), .rst(rst), .bus(b12.slave));

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // Instruction-level reference model (8-bit data, 16-word RAM)
  int  m_ram [16];
  int  m_a, m_b, m_out, m_cf, m_zf, m_cyc;
  bit  m_halt;
  int  m_outs [$];

  // Observations from the 8-bit DUT run
  int  d_outs [$];
  int  d_cyc, d_busy_low;
  bit  d_halt;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_ram[i]) m_ram[i] = 0;
    m_a = 0; m_b = 0; m_out = 0; m_cf = 0; m_zf = 0;
  endtask

  // Executes whole instructions; events finishing after the cycle budget are not visible.
  task automatic model_run(input int budget);
    int pc, ir, opc, op, s;
    pc = 0; m_cf = 0; m_zf = 0; m_cyc = 0; m_halt = 0;
    m_outs.delete();
    while (!m_halt && m_cyc < budget) begin
      ir = m_ram[pc];
      pc = (pc + 1) % 16;
      opc = ir / 16;
      op  = ir % 16;
      case (opc)
        1: begin m_a = m_ram[op]; m_cyc += 4; end
        2, 3: begin
          m_b = m_ram[op];
          s = (opc == 2) ? m_a + m_b : m_a + (255 - m_b) + 1;
          m_cf = (s > 255);
          m_a  = s % 256;
          m_zf = (m_a == 0);
          m_cyc += 5;
        end
        4: begin m_ram[op] = m_a; m_cyc += 4; end
        5: begin m_a = op; m_cyc += 3; end
        6: begin pc = op; m_cyc += 3; end
        7: begin if (m_cf != 0) pc = op; m_cyc += 3; end
        8: begin if (m_zf != 0) pc = op; m_cyc += 3; end
        14: begin
          if (m_cyc + 3 <= budget) begin m_outs.push_back(m_a); m_out = m_a; end
          m_cyc += 3;
        end
        15: begin
          if (m_cyc + 3 <= budget) m_halt = 1;
          m_cyc += 3;
        end
        default: m_cyc += 2;
      endcase
    end
  endtask

  task automatic load8(input int a, input int d);
    b8.prog_we = 1'b1; b8.prog_addr = 4'(a); b8.prog_data = 8'(d);
    cyc();
    b8.prog_we = 1'b0;
    m_ram[a] = d;
  endtask

  task automatic load12(input int a, input int d);
    b12.prog_we = 1'b1; b12.prog_addr = 6'(a); b12.prog_data = 12'(d);
    cyc();
    b12.prog_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_reset();
  endtask

  // Pulse run (any prog_we already set up rides along), then track until halt or budget.
  // For the first bw_n cycles of the run a host write to bw_addr is attempted.
  task automatic run_dut(input int budget, input int bw_n, input int bw_addr, input int bw_data);
    int k;
    d_outs.delete();
    d_busy_low = 0;
    k = 0;
    b8.run = 1'b1;
    cyc();
    b8.run = 1'b0;
    b8.prog_we = 1'b0;
    forever begin
      if (b8.out_valid) d_outs.push_back(int'(b8.out_data));
      if (!b8.halted && !b8.busy) d_busy_low++;
      if (b8.halted || k >= budget) break;
      b8.prog_we   = (k < bw_n);
      b8.prog_addr = 4'(bw_addr);
      b8.prog_data = 8'(bw_data);
      cyc();
      k++;
    end
    b8.prog_we = 1'b0;
    d_cyc  = k;
    d_halt = b8.halted;
  endtask

  task automatic compare_run(input string tag);
    chk({tag, "_halted"}, 32'(d_halt), 32'(m_halt));
    chk({tag, "_nouts"}, 32'(d_outs.size()), 32'(m_outs.size()));
    for (int i = 0; i < m_outs.size(); i++)
      chk({tag, "_outval"}, (i < d_outs.size()) ? 32'(d_outs[i]) : 32'hDEAD, 32'(m_outs[i]));
    if (m_halt) begin
      chk({tag, "_cycles"}, 32'(d_cyc), 32'(m_cyc));
      chk({tag, "_cf"}, 32'(b8.cf), 32'(m_cf));
      chk({tag, "_zf"}, 32'(b8.zf), 32'(m_zf));
      chk({tag, "_outreg"}, 32'(b8.out_data), 32'(m_out));
    end else begin
      chk({tag, "_busy"}, 32'(d_busy_low), 32'd0);
    end
  endtask

  task automatic run12(input int budget, output int cycles, output int nouts, output int first);
    int k;
    k = 0; nouts = 0; first = -1;
    b12.run = 1'b1;
    cyc();
    b12.run = 1'b0;
    b12.prog_we = 1'b0;
    forever begin
      if (b12.out_valid) begin
        if (nouts == 0) first = int'(b12.out_data);
        nouts++;
      end
      if (b12.halted || k >= budget) break;
      cyc();
      k++;
    end
    cycles = k;
  endtask

  initial begin
    int c12, n12, f12;
    rst = 1'b1;
    b8.prog_we = 0;  b8.prog_addr = 0;  b8.prog_data = 0;  b8.run = 0;
    b12.prog_we = 0; b12.prog_addr = 0; b12.prog_data = 0; b12.run = 0;
    cyc();
    cyc();
    chk("rst_out_data", 32'(b8.out_data), 32'd0);
    chk("rst_out_valid", 32'(b8.out_valid), 32'd0);
    chk("rst_halted", 32'(b8.halted), 32'd0);
    chk("rst_busy", 32'(b8.busy), 32'd0);
    chk("rst_cf", 32'(b8.cf), 32'd0);
    chk("rst_zf", 32'(b8.zf), 32'd0);
    chk("rst_busy12", 32'(b12.busy), 32'd0);
    rst = 1'b0;
    model_reset();

    // LDA 14, ADD 15, OUT, HLT with 5 + 7
    load8(0, 'h1E); load8(1, 'h2F); load8(2, 'hE0); load8(3, 'hF0);
    load8(14, 'h05); load8(15, 'h07);
    model_run(100);
    run_dut(100, 0, 0, 0);
    compare_run("basic");
    chk("basic_cyc_abs", 32'(d_cyc), 32'd15);
    chk("basic_out_abs", 32'(b8.out_data), 32'h0C);

    // Carry out of ADD sets CF and ZF, JC taken
    load8(0, 'h1E); load8(1, 'h2F); load8(2, 'h76); load8(3, 'hE0); load8(4, 'hF0);
    load8(6, 'h59); load8(7, 'hE0); load8(8, 'hF0); load8(14, 'hFF); load8(15, 'h01);
    model_run(100);
    run_dut(100, 0, 0, 0);
    compare_run("carry");
    chk("carry_out_abs", 32'(b8.out_data), 32'h09);
    chk("carry_cf_abs", 32'(b8.cf), 32'd1);

    // SUB 3-5 borrows, JZ not taken
    load8(0, 'h53); load8(1, 'h3F); load8(2, 'h85); load8(3, 'hE0); load8(4, 'hF0);
    load8(5, 'hF0); load8(15, 'h05);
    model_run(100);
    run_dut(100, 0, 0, 0);
    compare_run("sub");
    chk("sub_out_abs", 32'(b8.out_data), 32'hFE);

    // Self-modifying store to the next instruction
    load8(0, 'h1E); load8(1, 'h42); load8(2, 'hF0); load8(3, 'hE0); load8(4, 'hF0);
    load8(14, 'hE0);
    model_run(100);
    run_dut(100, 0, 0, 0);
    compare_run("selfmod");

    // Host writes while busy are ignored
    load8(0, 'h57); load8(1, 'hE0); load8(2, 'hF0);
    model_run(100);
    run_dut(100, 6, 1, 'hF0);
    compare_run("busy_we");

    // Write and run in the same HALT cycle
    b8.prog_we = 1'b1; b8.prog_addr = 4'd0; b8.prog_data = 8'h5A;
    m_ram[0] = 'h5A;
    model_run(100);
    run_dut(100, 0, 0, 0);
    compare_run("we_run");
    chk("we_run_out_abs", 32'(b8.out_data), 32'h0A);

    // Randomised programs from reset
    for (int t = 0; t < 8; t++) begin
      do_reset();
      for (int a = 0; a < 16; a++) load8(a, int'($urandom_range(0, 255)));
      model_run(300);
      run_dut(300, 0, 0, 0);
      compare_run("rand");
    end

    // Non-halting program wraps PC; then reset during F2 clears everything
    do_reset();
    load8(0, 'h5C); load8(1, 'hE0);
    model_run(40);
    run_dut(40, 0, 0, 0);
    compare_run("wrap");
    cyc();
    rst = 1'b1;
    cyc();
    chk("midrst_out_data", 32'(b8.out_data), 32'd0);
    chk("midrst_busy", 32'(b8.busy), 32'd0);
    chk("midrst_halted", 32'(b8.halted), 32'd0);
    chk("midrst_out_valid", 32'(b8.out_valid), 32'd0);
    rst = 1'b0;
    model_reset();
    model_run(30);
    run_dut(30, 0, 0, 0);
    compare_run("cleared");
    chk("cleared_nouts_abs", 32'(d_outs.size()), 32'd0);

    // 12-bit data, 6-bit address instance
    do_reset();
    load12(0, 'h5FF); load12(1, 'hE00); load12(2, 'hF00);
    run12(50, c12, n12, f12);
    chk("w12_ldi_out", 32'(f12), 32'h0FF);
    chk("w12_ldi_nouts", 32'(n12), 32'd1);
    chk("w12_ldi_cyc", 32'(c12), 32'd9);
    // JMP 63; STA 0 rewrites word 0 as a NOP; PC wraps to 0, then OUT, HLT
    load12(0, 'h63F); load12(63, 'h400);
    run12(50, c12, n12, f12);
    chk("w12_wrap_halted", 32'(b12.halted), 32'd1);
    chk("w12_wrap_cyc", 32'(c12), 32'd15);
    chk("w12_wrap_out", 32'(f12), 32'h0FF);
    chk("w12_wrap_nouts", 32'(n12), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
